// File: rtl/seq_display.sv
// Memory-game playback stage: steps the sequence counter, latches each ROM symbol and
// shows it on the LEDs with fixed on/off timing. Define SEQ_DISPLAY_BEEP_EN for the beep output.
module seq_display #(
    parameter int unsigned P_SYM       = 4,
    parameter int unsigned P_ON_CYC    = 50,
    parameter int unsigned P_OFF_CYC   = 25
`ifdef SEQ_DISPLAY_BEEP_EN
    ,
    parameter int unsigned P_BEEP_HALF = 8
`endif
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic             abort,
    input  logic [P_SYM-1:0] rom_data,
    input  logic             tc,
    output logic             cnt_E,
    output logic             cnt_R,
    output logic [P_SYM-1:0] leds,
    output logic             busy,
    output logic             done
`ifdef SEQ_DISPLAY_BEEP_EN
    ,
    output logic             beep
`endif
);

    localparam int unsigned MAX_ONOFF = (P_ON_CYC > P_OFF_CYC) ? P_ON_CYC : P_OFF_CYC;
    localparam int unsigned MAX_LOAD  = (MAX_ONOFF > 2) ? MAX_ONOFF : 2;
    localparam int unsigned TW        = $clog2(MAX_LOAD) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SETTLE,
        S_ON,
        S_OFF,
        S_STEP,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [P_SYM-1:0]  sym_q, sym_d;
    logic [P_SYM-1:0]  leds_d;
    logic              cnt_e_d, cnt_r_d, busy_d, done_d;

    // State, timer, latched symbol and registered outputs
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            sym_q   <= '0;
            cnt_E   <= 1'b0;
            cnt_R   <= 1'b0;
            leds    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sym_q   <= sym_d;
            cnt_E   <= cnt_e_d;
            cnt_R   <= cnt_r_d;
            leds    <= leds_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state; outputs are computed for the cycle after the edge
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
        sym_d   = sym_q;
        leds_d  = '0;
        cnt_e_d = 1'b0;
        cnt_r_d = 1'b0;
        done_d  = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            timer_d = '0;
            cnt_r_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLR;
                        cnt_r_d = 1'b1;
                    end
                end
                S_CLR: begin
                    state_d = S_SETTLE;
                    timer_d = TW'(2);
                end
                S_SETTLE: begin
                    if (timer_q == TW'(1)) begin
                        state_d = S_ON;
                        timer_d = TW'(P_ON_CYC);
                        sym_d   = rom_data;
                        leds_d  = rom_data;
                    end
                end
                S_ON: begin
                    if (timer_q == TW'(1)) begin
                        state_d = S_OFF;
                        timer_d = TW'(P_OFF_CYC);
                    end else begin
                        leds_d = sym_q;
                    end
                end
                S_OFF: begin
                    // tc only matters on the final blank cycle
                    if (timer_q == TW'(1)) begin
                        if (tc) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_STEP;
                            cnt_e_d = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    state_d = S_SETTLE;
                    timer_d = TW'(2);
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef SEQ_DISPLAY_BEEP_EN
    localparam int unsigned BW = $clog2(P_BEEP_HALF) + 1;

    logic [BW-1:0] bcnt_q;

    // Square wave during ON, phase restarts high on every ON entry
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            bcnt_q <= '0;
            beep   <= 1'b0;
        end else if (state_d != S_ON) begin
            bcnt_q <= '0;
            beep   <= 1'b0;
        end else if (state_q != S_ON) begin
            bcnt_q <= '0;
            beep   <= 1'b1;
        end else if (bcnt_q == BW'(P_BEEP_HALF - 1)) begin
            bcnt_q <= '0;
            beep   <= ~beep;
        end else begin
            bcnt_q <= bcnt_q + BW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_display.sv
// Self-checking bench for seq_display: counter/ROM environment plus a cycle-table
// reference built from symbol count and on/off/step timing.
module tb_seq_display;

    localparam int unsigned ON     = 4;
    localparam int unsigned OFF    = 2;
    localparam int unsigned SYM    = 4;
    localparam int          MAXCYC = 64;
`ifdef SEQ_DISPLAY_BEEP_EN
    localparam int unsigned HALF   = 2;
`endif

    logic           clk = 1'b0;
    logic           R = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [SYM-1:0] rom_q;
    logic           tc;
    logic           cnt_E, cnt_R, busy, done;
    logic [SYM-1:0] leds;
`ifdef SEQ_DISPLAY_BEEP_EN
    logic           beep;
`endif

    logic [SYM-1:0] rom_tab [0:7];
    logic [2:0]     addr;
    int             n_sym = 1;

    // {beep, cnt_R, cnt_E, busy, done, leds}
    logic [8:0]     obs   [0:MAXCYC-1];
    logic [8:0]     exp_v [0:MAXCYC-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_display #(
        .P_SYM(SYM),
        .P_ON_CYC(ON),
        .P_OFF_CYC(OFF)
`ifdef SEQ_DISPLAY_BEEP_EN
        ,
        .P_BEEP_HALF(HALF)
`endif
    ) dut (
        .clk(clk),
        .R(R),
        .start(start),
        .abort(abort),
        .rom_data(rom_q),
        .tc(tc),
        .cnt_E(cnt_E),
        .cnt_R(cnt_R),
        .leds(leds),
        .busy(busy),
        .done(done)
`ifdef SEQ_DISPLAY_BEEP_EN
        ,
        .beep(beep)
`endif
    );

    // Sequence counter with a registered ROM behind it
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            addr  <= '0;
            rom_q <= '0;
        end else begin
            if (cnt_R)      addr <= '0;
            else if (cnt_E) addr <= addr + 3'd1;
            rom_q <= rom_tab[addr];
        end
    end
    assign tc = (addr == 3'(n_sym - 1));

    function automatic logic [8:0] sample();
        logic b;
        b = 1'b0;
`ifdef SEQ_DISPLAY_BEEP_EN
        b = beep;
`endif
        return {b, cnt_R, cnt_E, busy, done, leds};
    endfunction

    // Expected per-cycle table; cycle k is the k-th cycle after the start edge
    task automatic build_expected(input int n, output int dcyc);
        int on0;
        for (int k = 0; k < MAXCYC; k++) exp_v[k] = '0;
        dcyc = 1 + 2 + n * (ON + OFF) + (n - 1) * 3 + 1;
        for (int k = 1; k <= dcyc; k++) exp_v[k][5] = 1'b1;
        exp_v[1][7]    = 1'b1;
        exp_v[dcyc][4] = 1'b1;
        for (int i = 0; i < n; i++) begin
            on0 = 4 + i * (ON + OFF + 3);
            for (int j = 0; j < ON; j++) begin
                exp_v[on0 + j][3:0] = rom_tab[i];
`ifdef SEQ_DISPLAY_BEEP_EN
                exp_v[on0 + j][8] = (((j / HALF) % 2) == 0);
`endif
            end
            if (i < n - 1) exp_v[on0 + ON + OFF][6] = 1'b1;
        end
    endtask

    task automatic play(input int ncyc, input int extra_start, input int abort_at,
                        input bit abort_with_start);
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            obs[k] = sample();
            start  = (k == extra_start);
            abort  = (k == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic load_three();
        n_sym      = 3;
        rom_tab[0] = 4'b0001;
        rom_tab[1] = 4'b0010;
        rom_tab[2] = 4'b1000;
    endtask

    task automatic test_reset();
        checks++;
        if (sample() !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle got %b exp %b", sample(), 9'd0);
        end
        n_sym      = 1;
        rom_tab[0] = 4'b0100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (leds !== 4'b0100) begin
            errors++;
            $display("FAIL reset_pre_on leds got %b exp %b", leds, 4'b0100);
        end
        R = 1'b0;
        #1;
        checks++;
        if (sample() !== 9'd0) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", sample(), 9'd0);
        end
        @(negedge clk);
        R = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sample() !== 9'd0) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", sample(), 9'd0);
        end
    endtask

    task automatic test_single();
        int d;
        n_sym      = 1;
        rom_tab[0] = 4'b0100;
        build_expected(1, d);
        play(d + 3, 0, 0, 1'b0);
        for (int k = 1; k <= d + 3; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL single cycle %0d got %b exp %b", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_three();
        int d;
        load_three();
        build_expected(3, d);
        play(d + 3, 0, 0, 1'b0);
        for (int k = 1; k <= d + 3; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL three cycle %0d got %b exp %b", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int d;
        load_three();
        build_expected(3, d);
        play(d + 3, 5, 0, 1'b0);
        for (int k = 1; k <= d + 3; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL start_busy cycle %0d got %b exp %b", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_abort();
        int d;
        int ab;
        load_three();
        build_expected(3, d);
        ab = 4 + 1 * (ON + OFF + 3) + ON;
        exp_v[ab + 1] = 9'b0_1000_0000;
        for (int k = ab + 2; k < MAXCYC; k++) exp_v[k] = '0;
        play(d + 3, 0, ab, 1'b0);
        for (int k = 1; k <= d + 3; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL abort cycle %0d got %b exp %b", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_start_abort_same();
        int d;
        n_sym      = 2;
        rom_tab[0] = 4'($urandom);
        rom_tab[1] = 4'($urandom);
        build_expected(2, d);
        play(d + 3, 0, 0, 1'b1);
        for (int k = 1; k <= d + 3; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL start_abort cycle %0d got %b exp %b", k, obs[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int n;
        int xs;
        for (int r = 0; r < 6; r++) begin
            n     = int'($urandom_range(1, 5));
            n_sym = n;
            for (int i = 0; i < n; i++) rom_tab[i] = 4'($urandom);
            build_expected(n, d);
            xs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, d)) : 0;
            play(d + 1, xs, 0, 1'b0);
            for (int k = 1; k <= d + 1; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL b2b round %0d n %0d cycle %0d got %b exp %b",
                             r, n, k, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom_tab[i] = '0;
        repeat (3) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_three();
        test_start_ignored();
        test_abort();
        test_start_abort_same();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
